// File: rtl/sc2110_sync_embed_module_if.sv
// rtl/sc2110_sync_embed_module_if.sv - pixel-in / word-out bus of the SC2110 sync embedder
interface sc2110_sync_embed_module_if;
  logic        i_ce;
  logic        i_en;
  logic [11:0] i_pix_data;
  logic        o_pix_req;
  logic        o_dvld;
  logic [11:0] o_data;
  logic        o_busy;
  logic        o_frame_done;

  // Drives strobe, enable and pixels; observes the generated stream
  modport master (
    output i_ce, i_en, i_pix_data,
    input  o_pix_req, o_dvld, o_data, o_busy, o_frame_done
  );

  // The embedder itself
  modport slave (
    input  i_ce, i_en, i_pix_data,
    output o_pix_req, o_dvld, o_data, o_busy, o_frame_done
  );
endinterface

// File: rtl/sc2110_sync_embed_module.sv
// rtl/sc2110_sync_embed_module.sv - SC2110 transmit-side sync code embedder
module sc2110_sync_embed_module #(
  parameter int          H_ACTIVE   = 1920,
  parameter int          H_BLANK    = 280,
  parameter int          V_ACTIVE   = 1080,
  parameter int          V_BLANK    = 4400,
  parameter logic [11:0] BLANK_WORD = 12'h040
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  sc2110_sync_embed_module_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, FS, SAV, ACT, EAV, HBLK, FE, VBLK} state_t;

  localparam logic [15:0] H_ACT_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] H_BLK_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] V_ACT_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] V_BLK_LAST = 16'(V_BLANK - 1);

  localparam logic [11:0] TAG_FS  = 12'hAB0;
  localparam logic [11:0] TAG_SAV = 12'h800;
  localparam logic [11:0] TAG_EAV = 12'h9D0;
  localparam logic [11:0] TAG_FE  = 12'hB60;

  state_t      state;
  logic [1:0]  code_cnt;
  logic [15:0] pix_cnt;   // word counter for ACT, HBLK and VBLK runs
  logic [15:0] line_cnt;
  logic [11:0] data_q;
  logic        dvld_q;
  logic        busy_q;
  logic        done_q;
  logic [11:0] pix_clamped;

  // Sync preamble is FFF,000,000,tag; word index comes from the 2-bit code counter
  function automatic logic [11:0] code_word(input logic [1:0] idx, input logic [11:0] tag);
    case (idx)
      2'd0:    return 12'hFFF;
      2'd3:    return tag;
      default: return 12'h000;
    endcase
  endfunction

  // FFF is reserved for the preamble, so payload can never fake a sync code
  assign pix_clamped = (bus.i_pix_data == 12'hFFF) ? 12'hFFE : bus.i_pix_data;

  // Pop is same-cycle so a first-word-fall-through source supplies this word's pixel
  assign bus.o_pix_req    = (state == ACT) && bus.i_ce;
  assign bus.o_data       = data_q;
  assign bus.o_dvld       = dvld_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = done_q;

  // Frame sequencer: everything advances only on word strobes, outputs registered
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IDLE;
      code_cnt <= 2'd0;
      pix_cnt  <= 16'd0;
      line_cnt <= 16'd0;
      data_q   <= 12'h000;
      dvld_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      dvld_q <= bus.i_ce;
      done_q <= 1'b0;
      if (bus.i_ce) begin
        busy_q <= (state != IDLE);
        case (state)
          IDLE: begin
            data_q <= BLANK_WORD;
            if (bus.i_en) begin
              state    <= FS;
              code_cnt <= 2'd0;
              line_cnt <= 16'd0;
            end
          end
          FS: begin
            data_q   <= code_word(code_cnt, TAG_FS);
            code_cnt <= code_cnt + 2'd1;
            if (code_cnt == 2'd3) state <= SAV;
          end
          SAV: begin
            data_q   <= code_word(code_cnt, TAG_SAV);
            code_cnt <= code_cnt + 2'd1;
            if (code_cnt == 2'd3) begin
              state   <= ACT;
              pix_cnt <= 16'd0;
            end
          end
          ACT: begin
            data_q <= pix_clamped;
            if (pix_cnt == H_ACT_LAST) begin
              state   <= EAV;
              pix_cnt <= 16'd0;
            end else begin
              pix_cnt <= pix_cnt + 16'd1;
            end
          end
          EAV: begin
            data_q   <= code_word(code_cnt, TAG_EAV);
            code_cnt <= code_cnt + 2'd1;
            if (code_cnt == 2'd3) begin
              state   <= HBLK;
              pix_cnt <= 16'd0;
            end
          end
          HBLK: begin
            data_q <= BLANK_WORD;
            if (pix_cnt == H_BLK_LAST) begin
              pix_cnt <= 16'd0;
              if (line_cnt < V_ACT_LAST) begin
                line_cnt <= line_cnt + 16'd1;
                state    <= SAV;
              end else begin
                state <= FE;
              end
            end else begin
              pix_cnt <= pix_cnt + 16'd1;
            end
          end
          FE: begin
            data_q   <= code_word(code_cnt, TAG_FE);
            code_cnt <= code_cnt + 2'd1;
            if (code_cnt == 2'd3) begin
              state   <= VBLK;
              pix_cnt <= 16'd0;
            end
          end
          VBLK: begin
            data_q <= BLANK_WORD;
            if (pix_cnt == V_BLK_LAST) begin
              state   <= IDLE;
              pix_cnt <= 16'd0;
              done_q  <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sc2110_sync_embed_module.sv
// tb/tb_sc2110_sync_embed_module.sv - self-checking bench for the SC2110 sync embedder
module tb_sc2110_sync_embed_module;

  localparam int          HA    = 4;
  localparam int          HB    = 2;
  localparam int          VA    = 2;
  localparam int          VB    = 3;
  localparam logic [11:0] BLANK = 12'h040;

  typedef struct {
    logic [11:0] w;
    logic        busy;
    logic        done;
  } item_t;

  logic clk;
  logic rstn;

  sc2110_sync_embed_module_if bus ();

  sc2110_sync_embed_module #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .BLANK_WORD(BLANK)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus.slave)
  );

  int          total = 0;
  int          bad   = 0;
  item_t       exp_q[$];
  logic [11:0] pix_q[$];
  logic [11:0] last_data;
  logic        last_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_code(input logic [11:0] tag);
    exp_q.push_back('{12'hFFF, 1'b1, 1'b0});
    exp_q.push_back('{12'h000, 1'b1, 1'b0});
    exp_q.push_back('{12'h000, 1'b1, 1'b0});
    exp_q.push_back('{tag,     1'b1, 1'b0});
  endtask

  // Expected stream for one frame preceded by the IDLE word that launches it.
  // mode 0: pixels 1..8; mode 1: random pixels with FFF,000,000 planted
  task automatic gen_frame(input int mode);
    logic [11:0] px[HA*VA];
    for (int i = 0; i < HA*VA; i++) begin
      if (mode == 0) px[i] = 12'(i + 1);
      else           px[i] = 12'($urandom_range(0, 4095));
    end
    if (mode == 1) begin
      px[2] = 12'hFFF;
      px[3] = 12'h000;
      px[4] = 12'h000;
    end
    for (int i = 0; i < HA*VA; i++) pix_q.push_back(px[i]);
    exp_q.push_back('{BLANK, 1'b0, 1'b0});
    push_code(12'hAB0);
    for (int l = 0; l < VA; l++) begin
      push_code(12'h800);
      for (int p = 0; p < HA; p++) begin
        logic [11:0] v;
        v = px[l*HA + p];
        exp_q.push_back('{(v == 12'hFFF) ? 12'hFFE : v, 1'b1, 1'b0});
      end
      push_code(12'h9D0);
      for (int b = 0; b < HB; b++) exp_q.push_back('{BLANK, 1'b1, 1'b0});
    end
    push_code(12'hB60);
    for (int b = 0; b < VB; b++) exp_q.push_back('{BLANK, 1'b1, (b == VB-1)});
  endtask

  // One clock: drive at negedge, observe pop request, check registered word after posedge
  task automatic step(input logic ce, input logic en);
    item_t it;
    logic  popped;
    @(negedge clk);
    bus.i_ce       = ce;
    bus.i_en       = en;
    bus.i_pix_data = (pix_q.size() > 0) ? pix_q[0] : 12'h000;
    #1;
    popped = bus.o_pix_req;
    if (!ce) chk("pix_req_without_ce", {11'd0, popped}, 12'd0);
    @(posedge clk);
    #1;
    if (popped && pix_q.size() > 0) void'(pix_q.pop_front());
    chk("dvld", {11'd0, bus.o_dvld}, {11'd0, ce});
    if (ce) begin
      if (exp_q.size() > 0) it = exp_q.pop_front();
      else                  it = '{BLANK, 1'b0, 1'b0};
      chk("data", bus.o_data, it.w);
      chk("busy", {11'd0, bus.o_busy}, {11'd0, it.busy});
      chk("frame_done", {11'd0, bus.o_frame_done}, {11'd0, it.done});
      last_data = it.w;
      last_busy = it.busy;
    end else begin
      chk("data_hold", bus.o_data, last_data);
      chk("busy_hold", {11'd0, bus.o_busy}, {11'd0, last_busy});
      chk("frame_done_idle", {11'd0, bus.o_frame_done}, 12'd0);
    end
  endtask

  task automatic drain(input string tag, input bit rand_ce);
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      step(rand_ce ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      cyc++;
    end
    chk(tag, 12'(exp_q.size()), 12'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, bus.o_data, 12'h000);
    chk({tag, "_dvld"}, {11'd0, bus.o_dvld}, 12'd0);
    chk({tag, "_busy"}, {11'd0, bus.o_busy}, 12'd0);
    chk({tag, "_done"}, {11'd0, bus.o_frame_done}, 12'd0);
    chk({tag, "_pix_req"}, {11'd0, bus.o_pix_req}, 12'd0);
  endtask

  initial begin
    rstn           = 1'b0;
    bus.i_ce       = 1'b0;
    bus.i_en       = 1'b0;
    bus.i_pix_data = 12'h000;
    last_data      = 12'h000;
    last_busy      = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1'b1;

    // Directed frame: continuous strobe, one-shot enable, pixels 1..8, then stays idle
    gen_frame(0);
    step(1'b1, 1'b1);
    drain("frame1_timeout", 1'b0);
    repeat (3) step(1'b1, 1'b0);

    // Random strobe gaps, random pixels including a would-be preamble
    gen_frame(1);
    step(1'b1, 1'b1);
    drain("frame2_timeout", 1'b1);
    repeat (2) step(1'b1, 1'b0);

    // Enable held: two frames separated by one IDLE word, enable dropped in line 2 of frame 2
    gen_frame(0);
    gen_frame(1);
    repeat (65) step(1'b1, 1'b1);
    drain("b2b_timeout", 1'b0);
    repeat (4) step(1'b1, 1'b0);

    // Asynchronous reset while emitting active pixels
    gen_frame(0);
    step(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    pix_q.delete();
    last_data = 12'h000;
    last_busy = 1'b0;
    bus.i_ce  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    gen_frame(0);
    step(1'b1, 1'b1);
    drain("post_reset_timeout", 1'b1);
    step(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc2110_sync_embed_module.md
# sc2110_sync_embed_module

Transmit-side counterpart of the SC2110 serdes sync decoder: generates a 12-bit word stream with embedded sync codes (frame start/end, line start/end) around active pixel data pulled from upstream. Sits in the sensor-emulation / loopback path between a pixel source (FWFT FIFO or pattern generator) and the serializer. The output stream can be fed back into the receive-side decoder.

## Interface
Parameters:
- H_ACTIVE, 1920: pixel words per line (>=1)
- H_BLANK, 280: filler words after each line-end code (>=1)
- V_ACTIVE, 1080: lines per frame (>=1)
- V_BLANK, 4400: filler words after frame-end code (>=1)
- BLANK_WORD, 12'h040: filler value

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_ce  in  1  word strobe; stream advances only on cycles with i_ce=1
- i_en  in  1  frame enable, level; sampled only in IDLE
- i_pix_data  in  12  pixel word, valid in the cycle o_pix_req=1
- o_pix_req  out  1  combinational pixel pop: (state==ACT) && i_ce
- o_dvld  out  1  output word valid
- o_data  out  12  output word
- o_busy  out  1  1 in any state other than IDLE
- o_frame_done  out  1  one-cycle pulse when last VBLK word is issued

## Operation
- State machine: IDLE, FS, SAV, ACT, EAV, HBLK, FE, VBLK. Transitions occur only on i_ce=1 cycles; with i_ce=0 all state and counters freeze.
- 4-word code states (FS, SAV, EAV, FE) emit FFF, 000, 000, then the tag word, using a 2-bit code counter:
  - FS tag 12'hAB0
  - SAV tag 12'h800
  - EAV tag 12'h9D0
  - FE tag 12'hB60
- IDLE: emits BLANK_WORD on each i_ce; goes to FS when i_en=1 on that i_ce cycle (the IDLE word is still emitted that cycle).
- Sequence:
  - FS(4) -> SAV(4) -> ACT(H_ACTIVE) -> EAV(4) -> HBLK(H_BLANK).
  - After HBLK, go to SAV if line_cnt < V_ACTIVE-1, else FE(4) -> VBLK(V_BLANK).
  - After VBLK, go to IDLE and pulse o_frame_done.
- i_en deasserting mid-frame has no effect; the current frame always completes. Back-to-back frames pass through one IDLE word.
- ACT: each word equals i_pix_data, except 12'hFFF, which is clamped to 12'hFFE. No payload can therefore form a sync preamble.
- Counters: pix_cnt and line_cnt are 16-bit, clear at the start of each line and frame respectively, and wrap only via explicit clear.
- Words per frame: 8 + V_ACTIVE*(8+H_ACTIVE+H_BLANK) + V_BLANK.

## Timing
- Reset values: o_data=12'h000, o_dvld=0, o_busy=0, o_frame_done=0, state IDLE, all counters 0. Reset mid-frame aborts immediately; no partial code completion.
- Latency: o_data and o_dvld are registered. The word chosen on an i_ce cycle appears on the next clock edge, together with o_dvld=1.
- With i_ce=0: o_dvld=0 next cycle and o_data holds its last value.
- o_pix_req is combinational, in the same cycle as i_ce. Upstream must present i_pix_data in that cycle (first-word-fall-through). Exactly H_ACTIVE pops per line, V_ACTIVE*H_ACTIVE per frame.
- o_busy is registered and rises with the first FS word on o_data.
- o_frame_done is aligned with the last VBLK word on o_data.

## Test plan
- Parameters H_ACTIVE=4, H_BLANK=2, V_ACTIVE=2, V_BLANK=3; i_ce=1; i_en pulsed once; pixels 1..8.
  - Required: 39-word frame, exactly FFF,000,000,AB0, FFF,000,000,800, 001..004, FFF,000,000,9D0, 040,040, second line 005..008, FE code ending B60, three 040 words.
  - Required: o_frame_done on the last word.
- Same parameters with i_ce toggling 1,0 in a random pattern. Required: identical o_dvld-qualified word sequence, o_data holds on o_dvld=0 cycles, and o_pix_req never asserts with i_ce=0.
- Pixel input 12'hFFF followed by 000,000. Required: output FFE,000,000 and no false sync.
- Loopback into the receive decoder. Required: fvld rises after the AB0 tag, two lvld windows of 4 valid words each with data 1..8 in order, fvld falls after B60.
- i_en held at 1. Required: consecutive frames separated by exactly one 040 IDLE word. Drop i_en mid-line. Required: the frame completes fully, then the block stays in IDLE.
- Assert i_rstn low during an ACT state, then release. Required: all outputs return to reset values asynchronously; the next frame starts with FS.
